// File: rtl/fhc_pkg.sv
// Shared opcode/condition constants, scoreboard entry layout and the branch
// condition evaluator for the fetch hazard controller.
package fhc_pkg;

    localparam logic [3:0]  OP_LW   = 4'h8;
    localparam logic [3:0]  OP_SW   = 4'h9;
    localparam logic [3:0]  OP_LHB  = 4'hA;
    localparam logic [3:0]  OP_LLB  = 4'hB;
    localparam logic [3:0]  OP_B    = 4'hC;
    localparam logic [3:0]  OP_JAL  = 4'hD;
    localparam logic [3:0]  OP_JR   = 4'hE;
    localparam logic [3:0]  OP_HLT  = 4'hF;

    localparam logic [2:0]  COND_NE  = 3'b000;
    localparam logic [2:0]  COND_EQ  = 3'b001;
    localparam logic [2:0]  COND_GT  = 3'b010;
    localparam logic [2:0]  COND_LT  = 3'b011;
    localparam logic [2:0]  COND_GE  = 3'b100;
    localparam logic [2:0]  COND_LE  = 3'b101;
    localparam logic [2:0]  COND_OV  = 3'b110;
    localparam logic [2:0]  COND_UNC = 3'b111;

    localparam logic [3:0]  R_LINK    = 4'd15;
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef struct packed {
        logic       valid;
        logic [3:0] dest;
        logic       is_load;
        logic       sets_flags;
    } sb_entry_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fhc_state_t;

    // flags = {Z, V, N}
    function automatic logic cond_true(input logic [2:0] cond, input logic [2:0] flags);
        logic z;
        logic v;
        logic n;
        logic r;
        z = flags[2];
        v = flags[1];
        n = flags[0];
        case (cond)
            COND_NE:  r = ~z;
            COND_EQ:  r = z;
            COND_GT:  r = ~z & ~n;
            COND_LT:  r = n;
            COND_GE:  r = ~n;
            COND_LE:  r = z | n;
            COND_OV:  r = v;
            COND_UNC: r = 1'b1;
            default:  r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/fetch_hazard_ctrl_if.sv
// Fetch-side bus between the PC/instruction memory and the fetch hazard controller.
interface fetch_hazard_ctrl_if #(
    parameter int DW = 16
);
    logic [DW-1:0] instr_in;
    logic [DW-1:0] pc_in;
    logic [2:0]    flags_in;
    logic [DW-1:0] id_instr;
    logic [DW-1:0] id_pc;
    logic          id_valid;
    logic          branch_s;
    logic [7:0]    b_offset;
    logic          jal_s;
    logic [11:0]   J_addr;
    logic          jr_s;
    logic          jstall;
    logic          stall;
    logic          hlt;

    modport master (
        output instr_in, pc_in, flags_in,
        input  id_instr, id_pc, id_valid, branch_s, b_offset, jal_s,
               J_addr, jr_s, jstall, stall, hlt
    );

    modport slave (
        input  instr_in, pc_in, flags_in,
        output id_instr, id_pc, id_valid, branch_s, b_offset, jal_s,
               J_addr, jr_s, jstall, stall, hlt
    );
endinterface

// File: rtl/fetch_hazard_ctrl_scoreboard.sv
// Shift register of instructions past ID (entry 0 = EX) with load-use,
// flag-producer and link-register match outputs.
module hazard_scoreboard
    import fhc_pkg::*;
#(
    parameter int         SB_DEPTH = 2,
    parameter logic [3:0] LINK_REG = 4'd15
) (
    input  logic      clk,
    input  logic      rst_n,
    input  sb_entry_t push,
    input  logic [3:0] src_a,
    input  logic [3:0] src_b,
    input  logic      src_a_used,
    input  logic      src_b_used,
    output logic      load_match,
    output logic      flag_match,
    output logic      link_match
);

    sb_entry_t sb_r [SB_DEPTH];

    // Shift ID's entry into EX and older entries toward MEM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                sb_r[i] <= '0;
            end
        end else begin
            sb_r[0] <= push;
            for (int i = 1; i < SB_DEPTH; i++) begin
                sb_r[i] <= sb_r[i-1];
            end
        end
    end

    // Only the EX entry can still be a load whose data is not yet forwardable.
    always_comb begin
        load_match = sb_r[0].valid & sb_r[0].is_load & (sb_r[0].dest != 4'd0) &
                     ((src_a_used & (src_a == sb_r[0].dest)) |
                      (src_b_used & (src_b == sb_r[0].dest)));
        flag_match = sb_r[0].valid & sb_r[0].sets_flags;
    end

    // Any pending writer of the link register blocks JR.
    always_comb begin
        link_match = 1'b0;
        for (int i = 0; i < SB_DEPTH; i++) begin
            link_match = link_match | (sb_r[i].valid & (sb_r[i].dest == LINK_REG));
        end
    end

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Owns the IF/ID register, decodes the instruction in ID and drives every PC
// control: branch/jump redirects, hazard stalls and the sticky halt.
module fetch_hazard_ctrl
    import fhc_pkg::*;
#(
    parameter int         DW       = 16,
    parameter int         SB_DEPTH = 2,
    parameter logic [3:0] R_LINK   = 4'd15
) (
    input  logic clk,
    input  logic rst_n,
    fetch_hazard_ctrl_if.slave bus
);

    logic [DW-1:0] id_instr_r;
    logic [DW-1:0] id_pc_r;
    logic          id_valid_r;
    fhc_state_t    state_r;
    fhc_state_t    state_nxt_s;

    logic [3:0] op_s;
    logic [3:0] src_a_s;
    logic [3:0] src_b_s;
    logic [3:0] dest_s;
    logic       src_a_used_s;
    logic       src_b_used_s;
    logic       is_load_s;
    logic       sets_flags_s;
    logic       is_b_s;
    logic       is_jal_s;
    logic       is_jr_s;
    logic       is_hlt_s;

    logic       load_match_s;
    logic       flag_match_s;
    logic       link_match_s;
    logic       load_use_s;
    logic       flag_haz_s;
    logic       link_haz_s;
    logic       stall_s;
    logic       halt_req_s;
    logic       flush_s;
    sb_entry_t  push_s;

    logic       ctl_branch_s;
    logic       ctl_jal_s;
    logic       ctl_jr_s;
    logic       ctl_jstall_s;
    logic       ctl_stall_s;
    logic       ctl_hlt_s;

    // Decode the ID instruction into register usage and class.
    always_comb begin
        op_s         = id_instr_r[15:12];
        src_a_s      = id_instr_r[7:4];
        src_b_s      = id_instr_r[3:0];
        src_a_used_s = 1'b0;
        src_b_used_s = 1'b0;
        dest_s       = 4'd0;
        is_load_s    = 1'b0;
        sets_flags_s = 1'b0;
        is_b_s       = 1'b0;
        is_jal_s     = 1'b0;
        is_jr_s      = 1'b0;
        is_hlt_s     = 1'b0;
        case (op_s)
            OP_LW: begin
                dest_s       = id_instr_r[11:8];
                src_a_used_s = 1'b1;
                is_load_s    = 1'b1;
            end
            OP_SW: begin
                src_a_used_s = 1'b1;
                src_b_s      = id_instr_r[11:8];
                src_b_used_s = 1'b1;
            end
            OP_LHB: begin
                dest_s       = id_instr_r[11:8];
                src_a_s      = id_instr_r[11:8];
                src_a_used_s = 1'b1;
            end
            OP_LLB: dest_s   = id_instr_r[11:8];
            OP_B:   is_b_s   = 1'b1;
            OP_JAL: begin
                is_jal_s     = 1'b1;
                dest_s       = R_LINK;
            end
            OP_JR:  is_jr_s  = 1'b1;
            OP_HLT: is_hlt_s = 1'b1;
            default: begin
                dest_s       = id_instr_r[11:8];
                src_a_used_s = 1'b1;
                src_b_used_s = 1'b1;
                sets_flags_s = 1'b1;
            end
        endcase
    end

    hazard_scoreboard #(
        .SB_DEPTH (SB_DEPTH),
        .LINK_REG (R_LINK)
    ) u_sb (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .src_a      (src_a_s),
        .src_b      (src_b_s),
        .src_a_used (src_a_used_s),
        .src_b_used (src_b_used_s),
        .load_match (load_match_s),
        .flag_match (flag_match_s),
        .link_match (link_match_s)
    );

    // Hazard qualification and the entry handed to EX (bubble while stalled).
    always_comb begin
        load_use_s = id_valid_r & load_match_s;
        flag_haz_s = id_valid_r & is_b_s & flag_match_s;
        link_haz_s = id_valid_r & is_jr_s & link_match_s;
        stall_s    = load_use_s | flag_haz_s | link_haz_s;
        halt_req_s = id_valid_r & is_hlt_s & ~stall_s;
        if (id_valid_r && !stall_s) begin
            push_s.valid      = 1'b1;
            push_s.dest       = dest_s;
            push_s.is_load    = is_load_s;
            push_s.sets_flags = sets_flags_s;
        end else begin
            push_s = '0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_RUN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: HALT is left only through reset.
    always_comb begin
        case (state_r)
            ST_RUN: begin
                if (halt_req_s) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_HALT: state_nxt_s = ST_HALT;
            default: state_nxt_s = ST_RUN;
        endcase
    end

    // FSM outputs: PC controls in RUN, only hlt in HALT.
    always_comb begin
        ctl_branch_s = 1'b0;
        ctl_jal_s    = 1'b0;
        ctl_jr_s     = 1'b0;
        ctl_jstall_s = 1'b0;
        ctl_stall_s  = 1'b0;
        ctl_hlt_s    = 1'b0;
        case (state_r)
            ST_RUN: begin
                ctl_branch_s = id_valid_r & is_b_s & ~flag_haz_s &
                               cond_true(id_instr_r[11:9], bus.flags_in);
                ctl_jal_s    = id_valid_r & is_jal_s;
                ctl_jr_s     = id_valid_r & is_jr_s;
                ctl_jstall_s = link_haz_s;
                ctl_stall_s  = stall_s;
                ctl_hlt_s    = halt_req_s;
            end
            ST_HALT: ctl_hlt_s = 1'b1;
            default: ctl_hlt_s = 1'b0;
        endcase
        flush_s = ctl_branch_s | ctl_jal_s | (ctl_jr_s & ~ctl_jstall_s);
    end

    // IF/ID register: hold on stall, bubble on redirect or halt, else load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid_r <= 1'b0;
            id_instr_r <= NOP_INSTR;
            id_pc_r    <= '0;
        end else if (ctl_stall_s) begin
            id_valid_r <= id_valid_r;
            id_instr_r <= id_instr_r;
            id_pc_r    <= id_pc_r;
        end else if (flush_s || ctl_hlt_s) begin
            id_valid_r <= 1'b0;
            id_instr_r <= NOP_INSTR;
            id_pc_r    <= bus.pc_in;
        end else begin
            id_valid_r <= 1'b1;
            id_instr_r <= bus.instr_in;
            id_pc_r    <= bus.pc_in;
        end
    end

    assign bus.id_instr = id_instr_r;
    assign bus.id_pc    = id_pc_r;
    assign bus.id_valid = id_valid_r;
    assign bus.b_offset = id_instr_r[7:0];
    assign bus.J_addr   = id_instr_r[11:0];
    assign bus.branch_s = ctl_branch_s;
    assign bus.jal_s    = ctl_jal_s;
    assign bus.jr_s     = ctl_jr_s;
    assign bus.jstall   = ctl_jstall_s;
    assign bus.stall    = ctl_stall_s;
    assign bus.hlt      = ctl_hlt_s;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Directed bench for fetch_hazard_ctrl: an instruction-level reference model
// checked every cycle, plus hand-computed pins on key cycles.
module tb_fetch_hazard_ctrl;

    localparam int PIN_NONE   = 0;
    localparam int PIN_VALID  = 1;
    localparam int PIN_BRANCH = 2;
    localparam int PIN_STALL  = 3;
    localparam int PIN_JAL    = 4;
    localparam int PIN_JSTALL = 5;
    localparam int PIN_HLT    = 6;
    localparam int PIN_PC     = 7;

    typedef struct {
        bit          rst;
        logic [15:0] ins;
        logic [15:0] pc;
        logic [2:0]  fl;
        int          ps;
        logic [15:0] pv;
    } vec_t;

    typedef struct packed {
        logic id_valid;
        logic branch;
        logic jal;
        logic jr;
        logic jstall;
        logic stall;
        logic hlt;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   pin_sel;
    logic [15:0] pin_val;
    vec_t vecs[$];

    bit          m_ok;
    bit          m_halt;
    bit          m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_pc;
    bit          h_v [2];
    logic [15:0] h_i [2];
    exp_t        cur_e;

    fetch_hazard_ctrl_if #(.DW(16)) bus ();

    fetch_hazard_ctrl #(.DW(16), .SB_DEPTH(2), .R_LINK(4'd15)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register written by an instruction (0 = none); JAL writes r15.
    function automatic logic [3:0] dest_of(input logic [15:0] ins);
        if (ins[15:12] <= 4'hB && ins[15:12] != 4'h9) return ins[11:8];
        else if (ins[15:12] == 4'hD) return 4'd15;
        else return 4'd0;
    endfunction

    function automatic bit reads(input logic [15:0] ins, input logic [3:0] r);
        case (ins[15:12])
            4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7:
                return (ins[7:4] == r) || (ins[3:0] == r);
            4'h8: return ins[7:4] == r;
            4'h9: return (ins[11:8] == r) || (ins[7:4] == r);
            4'hA: return ins[11:8] == r;
            default: return 1'b0;
        endcase
    endfunction

    // Condition outcome table indexed by cond, flags = {Z,V,N}.
    function automatic bit cond_ok(input logic [2:0] c, input logic [2:0] f);
        logic [7:0] t;
        t = {1'b1, f[1], f[2] | f[0], ~f[0], f[0], ~f[2] & ~f[0], f[2], ~f[2]};
        return t[c];
    endfunction

    function automatic exp_t model_out();
        exp_t e;
        logic [3:0] op;
        bit lu;
        bit fh;
        bit lh;
        e = '0;
        e.hlt = m_halt;
        if (m_valid) begin
            op = m_instr[15:12];
            lu = h_v[0] && h_i[0][15:12] == 4'h8 && dest_of(h_i[0]) != 4'd0 &&
                 reads(m_instr, dest_of(h_i[0]));
            fh = op == 4'hC && h_v[0] && h_i[0][15:12] < 4'h8;
            lh = op == 4'hE && ((h_v[0] && dest_of(h_i[0]) == 4'd15) ||
                                (h_v[1] && dest_of(h_i[1]) == 4'd15));
            e.id_valid = 1'b1;
            e.stall    = lu | fh | lh;
            e.jstall   = lh;
            e.jr       = op == 4'hE;
            e.jal      = op == 4'hD;
            e.branch   = op == 4'hC && !fh && cond_ok(m_instr[11:9], bus.flags_in);
            e.hlt      = m_halt | (op == 4'hF && !e.stall);
        end
        return e;
    endfunction

    always_comb cur_e = model_out();

    // Reference model advance on each clock edge.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_ok    <= 1'b1;
            m_halt  <= 1'b0;
            m_valid <= 1'b0;
            m_instr <= 16'h0000;
            m_pc    <= 16'h0000;
            h_v[0]  <= 1'b0;
            h_v[1]  <= 1'b0;
            h_i[0]  <= 16'h0000;
            h_i[1]  <= 16'h0000;
        end else begin
            h_v[1] <= h_v[0];
            h_i[1] <= h_i[0];
            h_v[0] <= m_valid && !cur_e.stall;
            h_i[0] <= m_instr;
            if (!cur_e.stall) begin
                if (cur_e.hlt || cur_e.branch || cur_e.jal || (cur_e.jr && !cur_e.jstall)) begin
                    m_valid <= 1'b0;
                    m_instr <= 16'h0000;
                end else begin
                    m_valid <= 1'b1;
                    m_instr <= bus.instr_in;
                    m_pc    <= bus.pc_in;
                end
            end
            if (cur_e.hlt) m_halt <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Compare DUT against the model and the per-cycle pin, away from the edge.
    always @(negedge clk) begin
        if (m_ok) begin
            chk("id_valid", 16'(bus.id_valid), 16'(cur_e.id_valid));
            chk("id_instr", bus.id_instr, m_instr);
            if (m_valid) chk("id_pc", bus.id_pc, m_pc);
            chk("b_offset", 16'(bus.b_offset), 16'(m_instr[7:0]));
            chk("J_addr", 16'(bus.J_addr), 16'(m_instr[11:0]));
            chk("branch_s", 16'(bus.branch_s), 16'(cur_e.branch));
            chk("jal_s", 16'(bus.jal_s), 16'(cur_e.jal));
            chk("jr_s", 16'(bus.jr_s), 16'(cur_e.jr));
            chk("jstall", 16'(bus.jstall), 16'(cur_e.jstall));
            chk("stall", 16'(bus.stall), 16'(cur_e.stall));
            chk("hlt", 16'(bus.hlt), 16'(cur_e.hlt));
            case (pin_sel)
                PIN_VALID:  chk("pin_id_valid", 16'(bus.id_valid), pin_val);
                PIN_BRANCH: chk("pin_branch_s", 16'(bus.branch_s), pin_val);
                PIN_STALL:  chk("pin_stall", 16'(bus.stall), pin_val);
                PIN_JAL:    chk("pin_jal_s", 16'(bus.jal_s), pin_val);
                PIN_JSTALL: chk("pin_jstall", 16'(bus.jstall), pin_val);
                PIN_HLT:    chk("pin_hlt", 16'(bus.hlt), pin_val);
                PIN_PC:     chk("pin_id_pc", bus.id_pc, pin_val);
                default:    ;
            endcase
        end
    end

    task automatic add(input bit r, input logic [15:0] ins, input logic [15:0] pc,
                       input logic [2:0] fl, input int ps, input logic [15:0] pv);
        vec_t t;
        t.rst = r; t.ins = ins; t.pc = pc; t.fl = fl; t.ps = ps; t.pv = pv;
        vecs.push_back(t);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        // reset, then B cond=001 (Z=1 taken, Z=0 not taken)
        add(1'b0, 16'h0000, 16'h0000, 3'b000, PIN_NONE,   16'h0000);
        add(1'b0, 16'h0000, 16'h0000, 3'b000, PIN_VALID,  16'h0000);
        add(1'b1, 16'hC205, 16'h0010, 3'b100, PIN_NONE,   16'h0000);
        add(1'b1, 16'hB101, 16'h0011, 3'b100, PIN_BRANCH, 16'h0001);
        add(1'b1, 16'hC205, 16'h0014, 3'b000, PIN_VALID,  16'h0000);
        // LW r3 ; ADD r4,r3,r1 ; LW r0 ; ADD r5,r0,r1
        add(1'b1, 16'h8320, 16'h0015, 3'b000, PIN_BRANCH, 16'h0000);
        add(1'b1, 16'h0431, 16'h0016, 3'b000, PIN_VALID,  16'h0001);
        add(1'b1, 16'h8020, 16'h0017, 3'b000, PIN_STALL,  16'h0001);
        add(1'b1, 16'h8020, 16'h0017, 3'b000, PIN_STALL,  16'h0000);
        add(1'b1, 16'h0501, 16'h0018, 3'b000, PIN_PC,     16'h0017);
        // B cond=001 right after ADD: flag stall, then taken on Z=1 to 0x1F
        add(1'b1, 16'hC207, 16'h0019, 3'b000, PIN_STALL,  16'h0000);
        add(1'b1, 16'hB101, 16'h001A, 3'b000, PIN_STALL,  16'h0001);
        add(1'b1, 16'hB101, 16'h001A, 3'b100, PIN_BRANCH, 16'h0001);
        // JAL 0x040 then JR at the target
        add(1'b1, 16'hD040, 16'h001F, 3'b000, PIN_VALID,  16'h0000);
        add(1'b1, 16'hB301, 16'h0020, 3'b000, PIN_JAL,    16'h0001);
        add(1'b1, 16'hE000, 16'h0040, 3'b000, PIN_VALID,  16'h0000);
        add(1'b1, 16'hB401, 16'h0041, 3'b000, PIN_JSTALL, 16'h0001);
        add(1'b1, 16'hB401, 16'h0041, 3'b000, PIN_JSTALL, 16'h0000);
        // return to 0x0020: HLT
        add(1'b1, 16'hF000, 16'h0020, 3'b000, PIN_VALID,  16'h0000);
        add(1'b1, 16'hB801, 16'h0021, 3'b000, PIN_HLT,    16'h0001);
        add(1'b1, 16'hB801, 16'h0021, 3'b000, PIN_VALID,  16'h0000);
        add(1'b1, 16'hB801, 16'h0021, 3'b100, PIN_HLT,    16'h0001);
        add(1'b1, 16'hB801, 16'h0021, 3'b000, PIN_STALL,  16'h0000);
        // reset while halted, then resume
        add(1'b0, 16'hB801, 16'h0021, 3'b000, PIN_HLT,    16'h0001);
        add(1'b0, 16'hB801, 16'h0021, 3'b000, PIN_HLT,    16'h0000);
        add(1'b1, 16'h0123, 16'h0030, 3'b000, PIN_VALID,  16'h0000);
        add(1'b1, 16'hB000, 16'h0031, 3'b000, PIN_PC,     16'h0030);
        add(1'b1, 16'h0000, 16'h0032, 3'b000, PIN_VALID,  16'h0001);

        foreach (vecs[i]) begin
            rst_n        = vecs[i].rst;
            bus.instr_in = vecs[i].ins;
            bus.pc_in    = vecs[i].pc;
            bus.flags_in = vecs[i].fl;
            pin_sel      = vecs[i].ps;
            pin_val      = vecs[i].pv;
            @(posedge clk);
            #1;
        end
        pin_sel = PIN_NONE;
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
